// File: rtl/axi_rd_burst_sequencer.sv
// Read DMA sequencer: splits one command into 4KB-safe INCR bursts,
// issues them on AXI4 AR one at a time and streams R beats out.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   cmd_*             command handshake (start address, beat count)
//   done, error       completion pulse, sticky error valid with done
//   m_axi_ar*         AXI4 read address channel (master side)
//   m_axi_r*          AXI4 read data channel (master side)
//   out_*             valid/ready beat stream to the consumer
module axi_rd_burst_sequencer #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 128,
  parameter int ID_WIDTH   = 4,
  parameter int MAX_BURST  = 16,
  parameter int AXI_ID     = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [15:0]           cmd_beats,
  output logic                  done,
  output logic                  error,
  output logic [ID_WIDTH-1:0]   m_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [ID_WIDTH-1:0]   m_axi_rid,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int BPB = DATA_WIDTH / 8;
  localparam int SZ  = $clog2(BPB);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    DONE
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [15:0]           rem;
  logic [8:0]            blen;
  logic [8:0]            bcnt;

  logic [ADDR_WIDTH-1:0] cmd_al;
  logic [ADDR_WIDTH-1:0] addr_nx;
  logic [15:0]           rem_nx;
  logic [8:0]            bl_cmd;
  logic [8:0]            bl_nx;
  logic                  r_hs;
  logic                  last_beat;
  logic                  unused_rid;

  // Beats until the next 4KB page, capped by MAX_BURST and rem.
  function automatic logic [8:0] burst_len(
    input logic [ADDR_WIDTH-1:0] a,
    input logic [15:0]           r
  );
    logic [12:0] room;
    logic [16:0] b;
    room = 13'((13'd4096 - {1'b0, a[11:0]}) >> SZ);
    b    = {1'b0, r};
    if (b > 17'(MAX_BURST)) b = 17'(MAX_BURST);
    if (b > {4'd0, room})   b = {4'd0, room};
    return b[8:0];
  endfunction

  assign cmd_al    = cmd_addr & ~ADDR_WIDTH'(BPB - 1);
  assign addr_nx   = addr + (ADDR_WIDTH'(blen) << SZ);
  assign rem_nx    = rem - 16'd1;
  assign bl_cmd    = burst_len(cmd_al, cmd_beats);
  assign bl_nx     = burst_len(addr_nx, rem_nx);
  assign r_hs      = (state == DATA) && m_axi_rvalid && out_ready;
  assign last_beat = (bcnt == 9'd1);
  assign unused_rid = ^m_axi_rid;

  assign cmd_ready     = (state == IDLE);
  assign m_axi_arid    = ID_WIDTH'(AXI_ID);
  assign m_axi_arsize  = 3'(SZ);
  assign m_axi_arburst = 2'b01;

  // Zero-latency R passthrough while a burst is in flight.
  assign out_data     = m_axi_rdata;
  assign out_valid    = (state == DATA) && m_axi_rvalid;
  assign m_axi_rready = (state == DATA) && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      addr          <= '0;
      rem           <= '0;
      blen          <= '0;
      bcnt          <= '0;
      m_axi_araddr  <= '0;
      m_axi_arlen   <= '0;
      m_axi_arvalid <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
    end else begin
      done <= 1'b0;
      if (done) error <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cmd_valid) begin
            error <= 1'b0;
            addr  <= cmd_al;
            rem   <= cmd_beats;
            if (cmd_beats == 16'd0) begin
              state <= DONE;
            end else begin
              blen          <= bl_cmd;
              bcnt          <= bl_cmd;
              m_axi_araddr  <= cmd_al;
              m_axi_arlen   <= 8'(bl_cmd - 9'd1);
              m_axi_arvalid <= 1'b1;
              state         <= ADDR;
            end
          end
        end
        ADDR: begin
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            state         <= DATA;
          end
        end
        DATA: begin
          if (r_hs) begin
            rem  <= rem_nx;
            bcnt <= bcnt - 9'd1;
            // rlast is only cross-checked; beat count ends the burst.
            if (m_axi_rresp != 2'b00 ||
                m_axi_rlast != last_beat)
              error <= 1'b1;
            if (last_beat) begin
              addr <= addr_nx;
              if (rem_nx == 16'd0) begin
                state <= DONE;
              end else begin
                blen          <= bl_nx;
                bcnt          <= bl_nx;
                m_axi_araddr  <= addr_nx;
                m_axi_arlen   <= 8'(bl_nx - 9'd1);
                m_axi_arvalid <= 1'b1;
                state         <= ADDR;
              end
            end
          end
        end
        DONE: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_rd_burst_sequencer.sv
// Bench for axi_rd_burst_sequencer: vector table, AXI slave model
// and queue scoreboard for AR bursts and streamed data.
module tb_axi_rd_burst_sequencer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [31:0]  cmd_addr;
  logic [15:0]  cmd_beats;
  logic         done;
  logic         error;
  logic [3:0]   m_axi_arid;
  logic [31:0]  m_axi_araddr;
  logic [7:0]   m_axi_arlen;
  logic [2:0]   m_axi_arsize;
  logic [1:0]   m_axi_arburst;
  logic         m_axi_arvalid;
  logic         m_axi_arready = 1'b0;
  logic [3:0]   m_axi_rid = 4'd0;
  logic [127:0] m_axi_rdata = '0;
  logic [1:0]   m_axi_rresp = 2'b00;
  logic         m_axi_rlast = 1'b0;
  logic         m_axi_rvalid = 1'b0;
  logic         m_axi_rready;
  logic [127:0] out_data;
  logic         out_valid;
  logic         out_ready = 1'b1;

  always #5 clk = ~clk;

  axi_rd_burst_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_addr      (cmd_addr),
    .cmd_beats     (cmd_beats),
    .done          (done),
    .error         (error),
    .m_axi_arid    (m_axi_arid),
    .m_axi_araddr  (m_axi_araddr),
    .m_axi_arlen   (m_axi_arlen),
    .m_axi_arsize  (m_axi_arsize),
    .m_axi_arburst (m_axi_arburst),
    .m_axi_arvalid (m_axi_arvalid),
    .m_axi_arready (m_axi_arready),
    .m_axi_rid     (m_axi_rid),
    .m_axi_rdata   (m_axi_rdata),
    .m_axi_rresp   (m_axi_rresp),
    .m_axi_rlast   (m_axi_rlast),
    .m_axi_rvalid  (m_axi_rvalid),
    .m_axi_rready  (m_axi_rready),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready)
  );

  typedef struct {
    logic [31:0] addr;
    int          beats;
    int          ar_delay;
    int          err_burst;
    int          bad_rlast;
    bit          rnd;
    int          exp_nb;
    bit          exp_err;
  } vec_t;

  int n_chk = 0;
  int n_fail = 0;
  int nb_seen = 0;
  int cfg_delay = 0;
  int cfg_err = -1;
  int cfg_badl = -1;
  bit cfg_rnd = 1'b0;

  logic [39:0]  ar_q[$];
  logic [127:0] d_q[$];

  task automatic check(input string nm,
                       input logic [127:0] got,
                       input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, got, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s", nm);
  endtask

  function automatic logic [127:0] mem(input logic [31:0] a);
    return {a, a ^ 32'hA5A5_5A5A, ~a, a + 32'h1357_9BDF};
  endfunction

  // Walk beat by beat, closing a burst at 16 beats or a page edge.
  task automatic model(input vec_t v);
    logic [31:0] a;
    logic [31:0] s;
    int r;
    int n;
    a = v.addr & 32'hFFFF_FFF0;
    r = v.beats;
    while (r > 0) begin
      s = a;
      n = 0;
      do begin
        d_q.push_back(mem(a));
        a = a + 32'd16;
        n++;
        r--;
      end while (r > 0 && n < 16 && a[11:0] != 12'h0);
      ar_q.push_back({s, 8'(n - 1)});
    end
  endtask

  // AXI slave model plus output monitor.
  initial begin : slave
    logic ar_hs, r_hs, o_hs, cmd_hs, arv, pend;
    logic [31:0] s_addr, p_addr;
    logic [7:0]  p_len;
    logic [39:0] e;
    logic [127:0] ed;
    int s_left, bidx, wcnt;
    bit s_act;
    pend = 1'b0; s_act = 1'b0; bidx = 0; wcnt = 0;
    s_left = 0; s_addr = '0; p_addr = '0; p_len = '0;
    forever begin
      @(negedge clk);
      ar_hs  = m_axi_arvalid && m_axi_arready;
      r_hs   = m_axi_rvalid && m_axi_rready;
      o_hs   = out_valid && out_ready;
      cmd_hs = cmd_valid && cmd_ready;
      arv    = m_axi_arvalid;
      if (rst_n) begin
        if (pend) begin
          check("ar_hold_valid", m_axi_arvalid, 1'b1);
          check("ar_hold_addr", m_axi_araddr, p_addr);
          check("ar_hold_len", m_axi_arlen, p_len);
        end
        if (ar_hs) begin
          nb_seen++;
          if (ar_q.size() == 0) begin
            fail_now("ar_unexpected");
          end else begin
            e = ar_q.pop_front();
            check("araddr", m_axi_araddr, e[39:8]);
            check("arlen", m_axi_arlen, e[7:0]);
          end
          check("arsize", m_axi_arsize, 3'd4);
          check("arburst", m_axi_arburst, 2'b01);
          check("arid", m_axi_arid, 4'd0);
        end
        if (s_act) begin
          check("rready_track", m_axi_rready, out_ready);
          check("out_valid_track", out_valid, m_axi_rvalid);
        end
        if (o_hs) begin
          if (d_q.size() == 0) begin
            fail_now("beat_unexpected");
          end else begin
            ed = d_q.pop_front();
            check("out_data", out_data, ed);
          end
        end
        pend   = arv && !m_axi_arready;
        p_addr = m_axi_araddr;
        p_len  = m_axi_arlen;
      end else begin
        pend = 1'b0;
      end
      @(posedge clk);
      #1;
      if (!rst_n) begin
        s_act = 1'b0;
        wcnt  = 0;
        bidx  = 0;
      end else begin
        if (cmd_hs) bidx = 0;
        if (r_hs && s_act) begin
          s_addr = s_addr + 32'd16;
          s_left--;
          if (s_left == 0) begin
            s_act = 1'b0;
            bidx++;
          end
        end
        if (ar_hs) begin
          s_act  = 1'b1;
          s_addr = p_addr;
          s_left = int'(p_len) + 1;
          wcnt   = 0;
        end else if (arv) begin
          wcnt++;
        end
      end
      m_axi_arready = (wcnt >= cfg_delay);
      m_axi_rvalid  = s_act;
      m_axi_rdata   = s_act ? mem(s_addr) : '0;
      m_axi_rresp   = (s_act && bidx == cfg_err) ? 2'b10 : 2'b00;
      m_axi_rlast   = s_act && s_left == 1 && bidx != cfg_badl;
      out_ready     = cfg_rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic set_cfg(input vec_t v);
    cfg_delay = v.ar_delay;
    cfg_err   = v.err_burst;
    cfg_badl  = v.bad_rlast;
    cfg_rnd   = v.rnd;
  endtask

  task automatic run(input vec_t v);
    int lat;
    int nd;
    set_cfg(v);
    model(v);
    nb_seen = 0;
    @(negedge clk);
    check("cmd_ready_idle", cmd_ready, 1'b1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_addr  = v.addr;
    cmd_beats = 16'(v.beats);
    @(posedge clk);
    #1;
    // Keep a bogus command up while busy; it must be ignored.
    if (v.beats == 0) cmd_valid = 1'b0;
    else cmd_addr = 32'hDEAD_0000;
    lat = -1;
    nd  = 0;
    for (int k = 1; k <= 4000; k++) begin
      @(negedge clk);
      if (k == 1)
        check("arvalid_lat", m_axi_arvalid, v.beats != 0);
      if (k == 2) cmd_valid = 1'b0;
      if (done) begin
        nd++;
        if (lat < 0) lat = k;
        check("error_at_done", error, v.exp_err);
      end
      if (lat > 0 && k >= lat + 3) break;
    end
    if (lat < 0) fail_now("done_timeout");
    check("done_pulses", nd, 1);
    check("burst_count", nb_seen, v.exp_nb);
    check("ar_left", ar_q.size(), 0);
    check("beats_left", d_q.size(), 0);
    if (v.beats == 0) check("zero_done_lat", lat, 2);
    ar_q.delete();
    d_q.delete();
  endtask

  initial begin : main
    vec_t tv[9];
    vec_t rv;
    bit found;
    tv[0] = '{32'h0000_0000, 40, 0, -1, -1, 1'b0, 3, 1'b0};
    tv[1] = '{32'h0000_0F80, 20, 0, -1, -1, 1'b0, 2, 1'b0};
    tv[2] = '{32'h0000_0000,  0, 0, -1, -1, 1'b0, 0, 1'b0};
    tv[3] = '{32'h0000_0000, 40, 0,  1, -1, 1'b0, 3, 1'b1};
    tv[4] = '{32'h0000_0000, 40, 5, -1, -1, 1'b1, 3, 1'b0};
    tv[5] = '{32'h1234_5678,  5, 0, -1, -1, 1'b1, 1, 1'b0};
    tv[6] = '{32'hFFFF_FFF0,  3, 2, -1, -1, 1'b0, 2, 1'b0};
    tv[7] = '{32'h0000_0040, 20, 2, -1,  0, 1'b1, 2, 1'b1};
    tv[8] = '{32'h0000_0FF0,  1, 0, -1, -1, 1'b0, 1, 1'b0};

    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_beats = '0;
    rst_n     = 1'b1;
    #1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_done", done, 1'b0);
    check("rst_error", error, 1'b0);
    check("rst_arvalid", m_axi_arvalid, 1'b0);
    check("rst_rready", m_axi_rready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_araddr", m_axi_araddr, 32'h0);
    check("rst_arlen", m_axi_arlen, 8'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) run(tv[i]);

    // Reset while the second burst's address is stalled.
    rv = '{32'h0000_0000, 40, 5, -1, -1, 1'b0, 3, 1'b0};
    set_cfg(rv);
    model(rv);
    nb_seen = 0;
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_addr  = 32'h0;
    cmd_beats = 16'd40;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (nb_seen >= 1 && m_axi_arvalid && !m_axi_arready) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) fail_now("rst_wait_timeout");
    check("rst_pre_araddr", m_axi_araddr, 32'h100);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_async_arvalid", m_axi_arvalid, 1'b0);
    check("rst_async_cmd_ready", cmd_ready, 1'b1);
    ar_q.delete();
    d_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    rv = '{32'h0000_2000, 4, 0, -1, -1, 1'b0, 1, 1'b0};
    run(rv);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
